check_scoreboard: RTL and testbench
===================================

// Module: check_scoreboard
// PURPOSE
//  Downstream consumer of the checker's OpDone. Run-level pass/fail verdict for a program executed on the MIPS core.
//  Delays each issued instruction (pcEn=1) by the checker latency, then samples OpDone for that instruction.
//  Counts checked and failed instructions, records the first failure, and ends the run by count or by timeout.
// PARAMETERS
//  CHK_LAT   3      cycles from an issue (pcEn=1 with inst) to the OpDone for that instruction
//  CNT_W     16     width of all counters and of n_expected
//  TIMEOUT   64     idle cycles (no pcEn) in RUN before the run is aborted
// PORTS
//  clk              in   1      rising-edge clock
//  reset_n          in   1      synchronous reset, active-low
//  start            in   1      pulse: begin a run (accepted only in IDLE or DONE)
//  n_expected       in   CNT_W  number of instructions in the run; sampled on an accepted start
//  inst             in   32     instruction presented to the checker
//  pcEn             in   1      issue strobe, same timing as the checker's pcEn
//  OpDone           in   1      checker verdict, valid CHK_LAT cycles after the issue
//  busy             out  1      1 in RUN or DRAIN
//  done             out  1      1 in DONE
//  pass_all         out  1      done && fail_cnt==0 && !timeout
//  timeout          out  1      sticky: the run ended by TIMEOUT
//  overrun          out  1      sticky: pcEn seen after n_expected issues
//  issued_cnt       out  CNT_W  issues accepted in this run
//  checked_cnt      out  CNT_W  OpDone samples taken
//  fail_cnt         out  CNT_W  samples with OpDone==0
//  first_fail_inst  out  32     inst of the first failure; all ones if none
//  first_fail_idx   out  CNT_W  issue index (0-based) of the first failure; all ones if none
//  class_fail       out  7      sticky per op_class_e bit: that class had a failure
// BEHAVIOUR
//  Reset (reset_n==0 at posedge):
//   - state=IDLE; delay line flushed; all counters and flags 0.
//   - first_fail_* = all ones; outputs take these values at the next edge.
//   - Reset mid-run aborts the run; no partial verdict is kept.
//  FSM:
//   - IDLE -start-> RUN.
//   - RUN -(issued_cnt==n_expected after an issue)-> DRAIN.
//   - RUN -(TIMEOUT idle cycles)-> DONE.
//   - DRAIN -(delay line empty)-> DONE.
//   - DONE -start-> RUN.
//  start:
//   - An accepted start clears counters, flags, first_fail_* and the delay line, and latches n_expected.
//   - start in RUN or DRAIN is ignored.
//   - n_expected==0: start goes to DRAIN, then DONE one cycle later with pass_all=1.
//  Issue (RUN only, pcEn=1):
//   - Push {valid, inst, class, idx=issued_cnt} into the delay line; issued_cnt++.
//   - pcEn in IDLE or DONE is ignored.
//   - pcEn in DRAIN is not pushed and sets overrun.
//  Check:
//   - The delay-line tail is valid exactly CHK_LAT cycles after its push.
//   - Tail valid: checked_cnt++. If OpDone==0: fail_cnt++ and set class_fail[class].
//   - If fail_cnt was 0 before this failure, latch first_fail_inst and first_fail_idx.
//   - OpDone is ignored when the tail is invalid.
//  Simultaneous events:
//   - Issue and check in the same cycle are both applied.
//   - The last issue and the RUN->DRAIN transition happen in the same cycle.
//  Timeout counter:
//   - Cleared by every issue and on entry to RUN; counts only in RUN.
//   - Reaching TIMEOUT: DONE, timeout=1, delay line flushed. Pending checks are dropped, not counted.
//  Counters saturate at all ones; no wrap.
//  Opcode class decode (inst[31:26]):
//   - ADD_op->ALU_R, ADDI_op->ALU_I, LW_op->LOAD, SW_op->STORE.
//   - BEQ_op and BNE_op->BRANCH, J_op->JUMP, anything else->OTHER.
//  All outputs are registered; the verdict is stable while in DONE.
// STRUCTURE
//  AluCtrlSig_pkg: add typedef enum logic[2:0] op_class_e {ALU_R,ALU_I,LOAD,STORE,BRANCH,JUMP,OTHER}.
//  AluCtrlSig_pkg: add function op_class(opcode) -> op_class_e.
//  Local typedef sb_state_e {IDLE,RUN,DRAIN,DONE}.
//  Sub-module chk_delay_line #(WIDTH,DEPTH=CHK_LAT): shift register with valid bit, synchronous flush.
// TESTING
//  1) start n_expected=4; 4x ADD (funct ADD) back-to-back; OpDone=1 at t+3 each -> DONE; checked=4, fail=0, pass_all=1.
//  2) 3 issues; OpDone=0 only for idx1 (BEQ) -> fail_cnt=1, first_fail_idx=1, first_fail_inst=BEQ word, class_fail[BRANCH]=1.
//  3) n_expected=2; only 1 pcEn, then idle TIMEOUT=64 cycles -> DONE, timeout=1, pass_all=0, checked_cnt<=1.
//  4) n_expected=2; 3 pcEn pulses -> overrun=1, issued_cnt=2, third inst never checked.
//  5) reset_n=0 for 1 cycle mid-DRAIN -> IDLE, all counters 0, first_fail_* all ones; OpDone pulses afterwards ignored.
//  6) n_expected=0, start -> done=1 two cycles later, pass_all=1; start while busy -> no effect on counts.

Source files
------------

// File: rtl/check_scoreboard_pkg.sv
// Shared opcode constants and opcode-class decode for the run scoreboard.
package check_scoreboard_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2b;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_J     = 6'h02;

  localparam int N_CLASS = 7;

  typedef enum logic [2:0] {ALU_R, ALU_I, LOAD, STORE, BRANCH, JUMP, OTHER} op_class_e;

  // ADD is R-type, so every R-type word lands in ALU_R regardless of funct.
  function automatic op_class_e op_class(input logic [5:0] opcode);
    case (opcode)
      OPC_RTYPE:        op_class = ALU_R;
      OPC_ADDI:         op_class = ALU_I;
      OPC_LW:           op_class = LOAD;
      OPC_SW:           op_class = STORE;
      OPC_BEQ, OPC_BNE: op_class = BRANCH;
      OPC_J:            op_class = JUMP;
      default:          op_class = OTHER;
    endcase
  endfunction

endpackage

// File: rtl/check_scoreboard_delay_line.sv
// Fixed-latency shift register carrying one issue record plus its valid bit.
module chk_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             tail_vld,
  output logic [WIDTH-1:0] tail_data,
  output logic             empty
);

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] data_p [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= push;
      for (int i = 1; i < DEPTH; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Data is never reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    data_p[0] <= din;
    for (int i = 1; i < DEPTH; i++) data_p[i] <= data_p[i-1];
  end

  assign tail_vld  = vld_p[DEPTH-1];
  assign tail_data = data_p[DEPTH-1];
  assign empty     = ~|vld_p;

endmodule

// File: rtl/check_scoreboard.sv
// Run-level pass/fail scoreboard: delays each issue by the checker latency and
// samples OpDone for it, tracking counts, first failure and timeout/overrun.
module check_scoreboard
  import check_scoreboard_pkg::*;
#(
  parameter int CHK_LAT = 3,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_expected,
  input  logic [31:0]      inst,
  input  logic             pcEn,
  input  logic             OpDone,
  output logic             busy,
  output logic             done,
  output logic             pass_all,
  output logic             timeout,
  output logic             overrun,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [31:0]      first_fail_inst,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic [6:0]       class_fail
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} sb_state_e;

  typedef struct packed {
    logic [31:0]      inst;
    op_class_e        cls;
    logic [CNT_W-1:0] idx;
  } sb_entry_t;

  sb_state_e        state;
  logic [CNT_W-1:0] n_exp_q;
  logic [IDLE_W-1:0] idle_cnt;
  logic             accept_start, do_push, hit_timeout, flush;
  logic             tail_vld, dl_empty;
  logic [CNT_W-1:0] issued_inc;
  sb_entry_t        push_ent, tail_ent;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    accept_start = start && (state == IDLE || state == DONE);
    do_push      = (state == RUN) && pcEn;
    hit_timeout  = (state == RUN) && !pcEn && (idle_cnt == IDLE_W'(TIMEOUT - 1));
    flush        = accept_start || hit_timeout;
    issued_inc   = sat_inc(issued_cnt);
    push_ent     = '{inst: inst, cls: op_class(inst[31:26]), idx: issued_cnt};
  end

  chk_delay_line #(.WIDTH($bits(sb_entry_t)), .DEPTH(CHK_LAT)) u_delay (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (do_push),
    .din       (push_ent),
    .tail_vld  (tail_vld),
    .tail_data (tail_ent),
    .empty     (dl_empty)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      n_exp_q         <= '0;
      idle_cnt        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass_all        <= 1'b0;
      timeout         <= 1'b0;
      overrun         <= 1'b0;
      issued_cnt      <= '0;
      checked_cnt     <= '0;
      fail_cnt        <= '0;
      first_fail_inst <= '1;
      first_fail_idx  <= '1;
      class_fail      <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (accept_start) begin
          n_exp_q         <= n_expected;
          idle_cnt        <= '0;
          busy            <= 1'b1;
          done            <= 1'b0;
          pass_all        <= 1'b0;
          timeout         <= 1'b0;
          overrun         <= 1'b0;
          issued_cnt      <= '0;
          checked_cnt     <= '0;
          fail_cnt        <= '0;
          first_fail_inst <= '1;
          first_fail_idx  <= '1;
          class_fail      <= '0;
          state           <= (n_expected == '0) ? DRAIN : RUN;
        end
        RUN: begin
          if (pcEn) begin
            issued_cnt <= issued_inc;
            idle_cnt   <= '0;
            if (issued_inc == n_exp_q) state <= DRAIN;
          end else if (hit_timeout) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        DRAIN: begin
          if (pcEn) overrun <= 1'b1;
          // No check can land in the cycle the line is empty, so fail_cnt is final here.
          if (dl_empty) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            pass_all <= (fail_cnt == '0);
          end
        end
        default: state <= IDLE;
      endcase

      if (tail_vld) begin
        checked_cnt <= sat_inc(checked_cnt);
        if (!OpDone) begin
          fail_cnt                <= sat_inc(fail_cnt);
          class_fail[tail_ent.cls] <= 1'b1;
          if (fail_cnt == '0) begin
            first_fail_inst <= tail_ent.inst;
            first_fail_idx  <= tail_ent.idx;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_check_scoreboard.sv
// Randomized and directed bench for check_scoreboard against a queue-based run model.
module tb_check_scoreboard;

  localparam int CHK_LAT = 3;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 64;
  localparam int MAXC    = (1 << CNT_W) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, start, pcEn, OpDone;
  logic [CNT_W-1:0] n_expected;
  logic [31:0]      inst;
  logic             busy, done, pass_all, timeout, overrun;
  logic [CNT_W-1:0] issued_cnt, checked_cnt, fail_cnt, first_fail_idx;
  logic [31:0]      first_fail_inst;
  logic [6:0]       class_fail;

  check_scoreboard #(.CHK_LAT(CHK_LAT), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .n_expected(n_expected),
    .inst(inst), .pcEn(pcEn), .OpDone(OpDone), .busy(busy), .done(done),
    .pass_all(pass_all), .timeout(timeout), .overrun(overrun),
    .issued_cnt(issued_cnt), .checked_cnt(checked_cnt), .fail_cnt(fail_cnt),
    .first_fail_inst(first_fail_inst), .first_fail_idx(first_fail_idx),
    .class_fail(class_fail)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Reference model: outstanding checks are a queue of due-cycles.
  typedef struct {
    int          due;
    logic [31:0] inst;
    int          idx;
    logic        ok;
  } pend_t;

  pend_t       pend[$];
  int          cyc = 0;
  int          m_mode, m_nexp, m_issued, m_checked, m_fail, m_idle, m_ffidx;
  logic        m_to, m_ov;
  logic [31:0] m_ffi;
  logic [6:0]  m_cls;

  function automatic int sat(input int v);
    return (v == MAXC) ? v : v + 1;
  endfunction

  function automatic int cls_of(input logic [31:0] w);
    case (w[31:26])
      6'h00: return 0;
      6'h08: return 1;
      6'h23: return 2;
      6'h2b: return 3;
      6'h04, 6'h05: return 4;
      6'h02: return 5;
      default: return 6;
    endcase
  endfunction

  task automatic model_clear();
    m_issued = 0; m_checked = 0; m_fail = 0; m_idle = 0;
    m_to = 1'b0; m_ov = 1'b0; m_ffi = '1; m_ffidx = MAXC; m_cls = '0;
    pend.delete();
  endtask

  task automatic model_edge(input logic ok);
    pend_t e;
    bit    was_empty;
    cyc++;
    if (!reset_n) begin
      m_mode = M_IDLE;
      m_nexp = 0;
      model_clear();
      return;
    end
    was_empty = (pend.size() == 0);
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      m_checked = sat(m_checked);
      if (!OpDone) begin
        if (m_fail == 0) begin m_ffi = e.inst; m_ffidx = e.idx; end
        m_fail = sat(m_fail);
        m_cls[cls_of(e.inst)] = 1'b1;
      end
    end
    case (m_mode)
      M_IDLE, M_DONE: if (start) begin
        model_clear();
        m_nexp = int'(n_expected);
        m_mode = (m_nexp == 0) ? M_DRAIN : M_RUN;
      end
      M_RUN: begin
        if (pcEn) begin
          e.due = cyc + CHK_LAT; e.inst = inst; e.idx = m_issued; e.ok = ok;
          pend.push_back(e);
          m_issued = sat(m_issued);
          m_idle = 0;
          if (m_issued == m_nexp) m_mode = M_DRAIN;
        end else if (m_idle + 1 == TIMEOUT) begin
          m_mode = M_DONE; m_to = 1'b1; pend.delete();
        end else begin
          m_idle++;
        end
      end
      default: begin
        if (pcEn) m_ov = 1'b1;
        if (was_empty) m_mode = M_DONE;
      end
    endcase
  endtask

  task automatic compare_all();
    expect_eq("busy", busy, (m_mode == M_RUN || m_mode == M_DRAIN));
    expect_eq("done", done, m_mode == M_DONE);
    expect_eq("pass_all", pass_all, (m_mode == M_DONE) && m_fail == 0 && !m_to);
    expect_eq("timeout", timeout, m_to);
    expect_eq("overrun", overrun, m_ov);
    expect_eq("issued_cnt", issued_cnt, m_issued);
    expect_eq("checked_cnt", checked_cnt, m_checked);
    expect_eq("fail_cnt", fail_cnt, m_fail);
    expect_eq("first_fail_inst", first_fail_inst, m_ffi);
    expect_eq("first_fail_idx", first_fail_idx, m_ffidx);
    expect_eq("class_fail", class_fail, m_cls);
  endtask

  // Called at a negedge; drives one cycle of inputs, advances the model, compares.
  task automatic step(input logic st, input int ne, input logic pe, input logic [31:0] w, input logic ok);
    start = st; n_expected = ne[CNT_W-1:0]; pcEn = pe; inst = w;
    if (pend.size() > 0 && pend[0].due == cyc + 1) OpDone = pend[0].ok;
    else OpDone = 1'($urandom_range(0, 1));
    @(posedge clk);
    model_edge(ok);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, $urandom, 1'b1);
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (!done && k < bound) begin idle(1); k++; end
    expect_eq("wait_done", done, 1'b1);
  endtask

  logic [31:0] W_ADD, W_ADDI, W_BEQ, W_LW;
  logic [5:0]  ops [8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    W_ADD  = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    W_ADDI = {6'h08, 5'd1, 5'd4, 16'h0007};
    W_BEQ  = {6'h04, 5'd1, 5'd2, 16'h0010};
    W_LW   = {6'h23, 5'd5, 5'd6, 16'h0040};
    ops = '{6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h3f};
    reset_n = 1'b0; start = 1'b0; pcEn = 1'b0; OpDone = 1'b0; inst = '0; n_expected = '0;
    @(negedge clk);
    idle(2);
    expect_eq("rst_ffi", first_fail_inst, 32'hffff_ffff);
    expect_eq("rst_ffidx", first_fail_idx, 16'hffff);
    expect_eq("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    idle(2);

    // 1: four passing ADDs
    step(1'b1, 4, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1, W_ADD, 1'b1);
    wait_done(20);
    expect_eq("t1_checked", checked_cnt, 4);
    expect_eq("t1_fail", fail_cnt, 0);
    expect_eq("t1_pass", pass_all, 1'b1);

    // 2: failing BEQ at idx 1
    step(1'b1, 3, 1'b0, '0, 1'b1);
    step(1'b0, 0, 1'b1, W_ADDI, 1'b1);
    step(1'b0, 0, 1'b1, W_BEQ, 1'b0);
    step(1'b0, 0, 1'b1, W_LW, 1'b1);
    wait_done(20);
    expect_eq("t2_fail", fail_cnt, 1);
    expect_eq("t2_ffidx", first_fail_idx, 1);
    expect_eq("t2_ffi", first_fail_inst, W_BEQ);
    expect_eq("t2_branch", class_fail[4], 1'b1);
    expect_eq("t2_pass", pass_all, 1'b0);

    // 3: timeout
    step(1'b1, 2, 1'b0, '0, 1'b1);
    step(1'b0, 0, 1'b1, W_ADD, 1'b1);
    wait_done(TIMEOUT + 10);
    expect_eq("t3_timeout", timeout, 1'b1);
    expect_eq("t3_pass", pass_all, 1'b0);
    expect_eq("t3_checked_le1", checked_cnt <= 1, 1'b1);

    // 4: overrun
    step(1'b1, 2, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1, W_ADDI, 1'b1);
    wait_done(20);
    expect_eq("t4_overrun", overrun, 1'b1);
    expect_eq("t4_issued", issued_cnt, 2);
    expect_eq("t4_checked", checked_cnt, 2);

    // 5: reset mid-drain
    step(1'b1, 3, 1'b0, '0, 1'b1);
    step(1'b0, 0, 1'b1, W_ADD, 1'b1);
    step(1'b0, 0, 1'b1, W_BEQ, 1'b0);
    step(1'b0, 0, 1'b1, W_LW, 1'b1);
    idle(1);
    reset_n = 1'b0;
    idle(1);
    reset_n = 1'b1;
    expect_eq("t5_busy", busy, 1'b0);
    expect_eq("t5_issued", issued_cnt, 0);
    expect_eq("t5_ffi", first_fail_inst, 32'hffff_ffff);
    idle(6);
    expect_eq("t5_checked", checked_cnt, 0);
    expect_eq("t5_fail", fail_cnt, 0);

    // 6: empty run, then start while busy
    step(1'b1, 0, 1'b0, '0, 1'b1);
    expect_eq("t6_done0", done, 1'b0);
    idle(1);
    expect_eq("t6_done1", done, 1'b1);
    expect_eq("t6_pass", pass_all, 1'b1);
    step(1'b1, 5, 1'b0, '0, 1'b1);
    step(1'b0, 0, 1'b1, W_ADD, 1'b1);
    step(1'b0, 0, 1'b1, W_ADD, 1'b1);
    step(1'b1, 9, 1'b1, W_ADD, 1'b1);
    step(1'b0, 0, 1'b1, W_ADD, 1'b1);
    step(1'b0, 0, 1'b1, W_ADD, 1'b1);
    wait_done(20);
    expect_eq("t6_issued", issued_cnt, 5);
    expect_eq("t6_checked", checked_cnt, 5);

    // Random runs
    for (int r = 0; r < 10; r++) begin
      step(1'b1, $urandom_range(1, 12), 1'b0, '0, 1'b1);
      for (int k = 0; k < 40; k++) begin
        logic pe;
        pe = ($urandom_range(0, 9) < 6) && !(r == 3 && k > 1);
        step(($urandom_range(0, 19) == 0), $urandom_range(0, 12), pe,
             {ops[$urandom_range(0, 7)], 26'($urandom)}, ($urandom_range(0, 4) != 0));
      end
      wait_done(TIMEOUT + 10);
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
